// File: rtl/ro_buffer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ro_buffer_pkg : shared types, kind codes and tag helper          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ro_buffer_pkg;

   localparam int RO_BUFFER_SIZE = 16;

   typedef logic [4:0] ro_buffer_id_t;
   typedef logic [4:0] reg_t;

   typedef enum logic [1:0] {
      KIND_ALU    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_LOAD   = 2'd2,
      KIND_STORE  = 2'd3
   } kind_e;

   typedef struct packed {
      logic        busy;
      logic        ready;
      kind_e       kind;
      reg_t        rd;
      logic [31:0] value;
      logic [31:0] pred_pc;
      logic [31:0] next_pc;
   } rob_entry_t;

   // Tags run 1..size; tag 0 is reserved for "none".
   function automatic ro_buffer_id_t next_tag(input ro_buffer_id_t id, input int size);
      return (int'(id) >= size) ? ro_buffer_id_t'(1) : id + 5'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ro_buffer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ro_buffer_if : issue, completion-bus and commit signals of the ROB |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ro_buffer_if;
   import ro_buffer_pkg::*;

   logic          issue_from_issuer;
   logic [1:0]    kind_from_issuer;
   reg_t          rd_from_issuer;
   logic [31:0]   pred_pc_from_issuer;
   ro_buffer_id_t dest_to_issuer;
   ro_buffer_id_t query_id_from_issuer;
   logic          query_ready_to_issuer;
   logic [31:0]   query_value_to_issuer;

   ro_buffer_id_t dest_from_rss_bus;
   logic [31:0]   value_from_rss_bus;
   logic [31:0]   next_pc_from_rss_bus;
   ro_buffer_id_t dest_from_lsb_bus;
   logic [31:0]   value_from_lsb_bus;

   ro_buffer_id_t dest_to_reg_file;
   reg_t          rd_to_reg_file;
   logic [31:0]   value_to_reg_file;
   ro_buffer_id_t store_commit_to_lsb;
   logic          reset_to_rob_bus;
   logic [31:0]   pc_to_fetcher;
   logic          is_ro_buffer_full;

   modport slave (
      input  issue_from_issuer, kind_from_issuer, rd_from_issuer, pred_pc_from_issuer,
      input  query_id_from_issuer,
      input  dest_from_rss_bus, value_from_rss_bus, next_pc_from_rss_bus,
      input  dest_from_lsb_bus, value_from_lsb_bus,
      output dest_to_issuer, query_ready_to_issuer, query_value_to_issuer,
      output dest_to_reg_file, rd_to_reg_file, value_to_reg_file,
      output store_commit_to_lsb, reset_to_rob_bus, pc_to_fetcher, is_ro_buffer_full
   );

   modport master (
      output issue_from_issuer, kind_from_issuer, rd_from_issuer, pred_pc_from_issuer,
      output query_id_from_issuer,
      output dest_from_rss_bus, value_from_rss_bus, next_pc_from_rss_bus,
      output dest_from_lsb_bus, value_from_lsb_bus,
      input  dest_to_issuer, query_ready_to_issuer, query_value_to_issuer,
      input  dest_to_reg_file, rd_to_reg_file, value_to_reg_file,
      input  store_commit_to_lsb, reset_to_rob_bus, pc_to_fetcher, is_ro_buffer_full
   );

endinterface
`default_nettype wire

// File: rtl/ro_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ro_buffer : 16-entry reorder buffer, in-order commit, flush on   |
// |             branch mispredict                                    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ro_buffer #(
   parameter int RO_BUFFER_SIZE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdy,
   ro_buffer_if.slave bus
);
   import ro_buffer_pkg::*;

   rob_entry_t    entries_q [RO_BUFFER_SIZE];
   rob_entry_t    entries_d [RO_BUFFER_SIZE];
   ro_buffer_id_t head_q, head_d;
   ro_buffer_id_t tail_q, tail_d;
   logic [4:0]    count_q, count_d;

   ro_buffer_id_t dest_to_reg_file_q, dest_to_reg_file_d;
   reg_t          rd_to_reg_file_q, rd_to_reg_file_d;
   logic [31:0]   value_to_reg_file_q, value_to_reg_file_d;
   ro_buffer_id_t store_commit_q, store_commit_d;
   logic          reset_to_rob_bus_q, reset_to_rob_bus_d;
   logic [31:0]   pc_to_fetcher_q, pc_to_fetcher_d;

   logic          commit;
   logic          mispredict;
   logic          issue;
   logic          query_ready;
   logic [31:0]   query_value;

   assign issue = bus.issue_from_issuer && !reset_to_rob_bus_q;

   always_comb begin
      entries_d           = entries_q;
      head_d              = head_q;
      tail_d              = tail_q;
      count_d             = count_q;
      dest_to_reg_file_d  = '0;
      rd_to_reg_file_d    = '0;
      value_to_reg_file_d = '0;
      store_commit_d      = '0;
      reset_to_rob_bus_d  = 1'b0;
      pc_to_fetcher_d     = '0;
      commit              = 1'b0;
      mispredict          = 1'b0;

      if (!reset_to_rob_bus_q) begin
         for (int i = 0; i < RO_BUFFER_SIZE; i++) begin
            // Commit sees only the stored ready bit, so a result lands one edge before it retires.
            if (ro_buffer_id_t'(i + 1) == head_q && entries_q[i].busy && entries_q[i].ready) begin
               commit              = 1'b1;
               dest_to_reg_file_d  = head_q;
               rd_to_reg_file_d    = entries_q[i].rd;
               value_to_reg_file_d = entries_q[i].value;
               store_commit_d      = (entries_q[i].kind == KIND_STORE) ? head_q : '0;
               mispredict          = (entries_q[i].kind == KIND_BRANCH) &&
                                     (entries_q[i].next_pc != entries_q[i].pred_pc);
               pc_to_fetcher_d     = mispredict ? entries_q[i].next_pc : '0;
            end
            if (entries_q[i].busy) begin
               if (bus.dest_from_lsb_bus == ro_buffer_id_t'(i + 1)) begin
                  entries_d[i].ready = 1'b1;
                  entries_d[i].value = bus.value_from_lsb_bus;
               end
               if (bus.dest_from_rss_bus == ro_buffer_id_t'(i + 1)) begin
                  entries_d[i].ready   = 1'b1;
                  entries_d[i].value   = bus.value_from_rss_bus;
                  entries_d[i].next_pc = bus.next_pc_from_rss_bus;
               end
            end
            if (commit && ro_buffer_id_t'(i + 1) == head_q) begin
               entries_d[i] = '0;
            end
            if (issue && ro_buffer_id_t'(i + 1) == tail_q) begin
               entries_d[i] = '{busy:    1'b1,
                                ready:   (bus.kind_from_issuer == KIND_STORE),
                                kind:    kind_e'(bus.kind_from_issuer),
                                rd:      bus.rd_from_issuer,
                                value:   '0,
                                pred_pc: bus.pred_pc_from_issuer,
                                next_pc: '0};
            end
         end

         if (commit) begin
            head_d = next_tag(head_q, RO_BUFFER_SIZE);
         end
         if (issue) begin
            tail_d = next_tag(tail_q, RO_BUFFER_SIZE);
         end
         count_d = count_q + 5'(issue) - 5'(commit);

         if (mispredict) begin
            for (int i = 0; i < RO_BUFFER_SIZE; i++) begin
               entries_d[i] = '0;
            end
            head_d             = 5'd1;
            tail_d             = 5'd1;
            count_d            = '0;
            reset_to_rob_bus_d = 1'b1;
         end
      end
   end

   // Bus bypass lets the issuer pick up a value on the same cycle it is broadcast.
   always_comb begin
      query_ready = 1'b0;
      query_value = '0;
      for (int i = 0; i < RO_BUFFER_SIZE; i++) begin
         if (ro_buffer_id_t'(i + 1) == bus.query_id_from_issuer &&
             entries_q[i].busy && entries_q[i].ready) begin
            query_ready = 1'b1;
            query_value = entries_q[i].value;
         end
      end
      if (bus.query_id_from_issuer != '0) begin
         if (bus.dest_from_lsb_bus == bus.query_id_from_issuer) begin
            query_ready = 1'b1;
            query_value = bus.value_from_lsb_bus;
         end
         if (bus.dest_from_rss_bus == bus.query_id_from_issuer) begin
            query_ready = 1'b1;
            query_value = bus.value_from_rss_bus;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RO_BUFFER_SIZE; i++) begin
            entries_q[i] <= '0;
         end
         head_q              <= 5'd1;
         tail_q              <= 5'd1;
         count_q             <= '0;
         dest_to_reg_file_q  <= '0;
         rd_to_reg_file_q    <= '0;
         value_to_reg_file_q <= '0;
         store_commit_q      <= '0;
         reset_to_rob_bus_q  <= 1'b0;
         pc_to_fetcher_q     <= '0;
      end else if (rdy) begin
         entries_q           <= entries_d;
         head_q              <= head_d;
         tail_q              <= tail_d;
         count_q             <= count_d;
         dest_to_reg_file_q  <= dest_to_reg_file_d;
         rd_to_reg_file_q    <= rd_to_reg_file_d;
         value_to_reg_file_q <= value_to_reg_file_d;
         store_commit_q      <= store_commit_d;
         reset_to_rob_bus_q  <= reset_to_rob_bus_d;
         pc_to_fetcher_q     <= pc_to_fetcher_d;
      end
   end

   assign bus.dest_to_issuer        = tail_q;
   assign bus.query_ready_to_issuer = query_ready;
   assign bus.query_value_to_issuer = query_value;
   assign bus.dest_to_reg_file      = dest_to_reg_file_q;
   assign bus.rd_to_reg_file        = rd_to_reg_file_q;
   assign bus.value_to_reg_file     = value_to_reg_file_q;
   assign bus.store_commit_to_lsb   = store_commit_q;
   assign bus.reset_to_rob_bus      = reset_to_rob_bus_q;
   assign bus.pc_to_fetcher         = pc_to_fetcher_q;
   assign bus.is_ro_buffer_full     = (count_q >= 5'(RO_BUFFER_SIZE - 1));

endmodule
`default_nettype wire
